// File: rtl/acc_seq_pkg.sv
// Shared definitions for the accumulator write-side sequencer.
// Opcode and state encodings plus the fixed data width.
// Imported by the interface, the ALU and the sequencer.
package acc_seq_pkg;

  localparam int DATA_W = 4;

  typedef enum logic [2:0] {
    OP_LOAD = 3'b000,
    OP_ADD  = 3'b001,
    OP_SUB  = 3'b010,
    OP_AND  = 3'b011,
    OP_OR   = 3'b100,
    OP_XOR  = 3'b101,
    OP_MUL  = 3'b110,
    OP_NOT  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

endpackage

// File: rtl/acc_seq_if.sv
// Request/write bundle between a requester, the accumulator and the sequencer.
// Purely wiring, no latency.
// START is only honoured by the sequencer while BUSY is low.
interface acc_seq_if;
  import acc_seq_pkg::*;

  logic              START;
  logic [2:0]        OP;
  logic [DATA_W-1:0] B;
  logic [DATA_W-1:0] ACC_IN;
  logic              BUSY;
  logic              S;
  logic [DATA_W-1:0] W_DATA;
  logic              DONE;
  logic              CARRY;

  modport master (
    output START, OP, B, ACC_IN,
    input  BUSY, S, W_DATA, DONE, CARRY
  );

  modport slave (
    input  START, OP, B, ACC_IN,
    output BUSY, S, W_DATA, DONE, CARRY
  );

endinterface

// File: rtl/alu4_comb.sv
// 4-bit combinational ALU for every opcode except MUL.
// Zero latency.
// No flow control; MUL yields zero here since the sequencer computes it.
module alu4_comb
  import acc_seq_pkg::*;
(
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  logic [DATA_W:0] sum;

  // Decode opcode into result and carry; logic ops and LOAD/NOT clear carry
  always_comb begin
    result = '0;
    carry  = 1'b0;
    sum    = {1'b0, a} + {1'b0, b};
    case (op)
      OP_LOAD: result = b;
      OP_ADD: begin
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      OP_SUB: begin
        result = a - b;
        carry  = (a < b);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOT:  result = ~a;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/acc_sequencer.sv
// Sequences one accumulator write per accepted START: compute, then a single S pulse.
// S two edges after acceptance for ALU ops, five for the 4-cycle shift-add MUL.
// START is ignored while BUSY is high; there is no downstream backpressure.
module acc_sequencer
  import acc_seq_pkg::*;
(
  input logic      CLK,
  input logic      RST,
  acc_seq_if.slave bus
);

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [2*DATA_W-1:0] prod_q, prod_d;
  logic                busy_q, busy_d;
  logic                s_q, s_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   w_data_q, w_data_d;
  logic                carry_q, carry_d;

  logic [DATA_W-1:0]   alu_res;
  logic                alu_carry;
  logic [DATA_W-1:0]   a_cur;
  logic [2*DATA_W-1:0] prod_base;
  logic [2*DATA_W-1:0] addend;

  // A is read live from the accumulator in the first CALC cycle so that a
  // back-to-back operation sees the value written by its predecessor.
  alu4_comb u_alu (
    .op     (op_q),
    .a      (bus.ACC_IN),
    .b      (b_q),
    .result (alu_res),
    .carry  (alu_carry)
  );

  // Shift-add step: iteration 0 takes A live and starts a fresh product
  always_comb begin
    a_cur     = (cnt_q == 2'd0) ? bus.ACC_IN : a_q;
    prod_base = (cnt_q == 2'd0) ? '0 : prod_q;
    addend    = b_q[cnt_q] ? ({{DATA_W{1'b0}}, a_cur} << cnt_q) : '0;
  end

  // Next-state and next-output decode
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    b_d      = b_q;
    a_d      = a_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    busy_d   = busy_q;
    s_d      = 1'b0;
    done_d   = 1'b0;
    w_data_d = w_data_q;
    carry_d  = carry_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.START) begin
          state_d = ST_CALC;
          busy_d  = 1'b1;
          op_d    = bus.OP;
          b_d     = bus.B;
          cnt_d   = 2'd0;
        end
      end
      ST_CALC: begin
        if (op_q == OP_MUL) begin
          a_d    = a_cur;
          prod_d = prod_base + addend;
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d  = ST_WRITE;
            s_d      = 1'b1;
            done_d   = 1'b1;
            w_data_d = prod_d[DATA_W-1:0];
            carry_d  = |prod_d[2*DATA_W-1:DATA_W];
          end
        end else begin
          state_d  = ST_WRITE;
          s_d      = 1'b1;
          done_d   = 1'b1;
          w_data_d = alu_res;
          carry_d  = alu_carry;
        end
      end
      ST_WRITE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // All state and outputs registered; reset aborts any operation in flight
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      b_q      <= '0;
      a_q      <= '0;
      cnt_q    <= '0;
      prod_q   <= '0;
      busy_q   <= 1'b0;
      s_q      <= 1'b0;
      done_q   <= 1'b0;
      w_data_q <= '0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      b_q      <= b_d;
      a_q      <= a_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      busy_q   <= busy_d;
      s_q      <= s_d;
      done_q   <= done_d;
      w_data_q <= w_data_d;
      carry_q  <= carry_d;
    end
  end

  assign bus.BUSY   = busy_q;
  assign bus.S      = s_q;
  assign bus.DONE   = done_q;
  assign bus.W_DATA = w_data_q;
  assign bus.CARRY  = carry_q;

endmodule

// File: doc/acc_sequencer.md
# acc_sequencer

Multi-cycle operation sequencer that drives the write side of the 4-bit accumulator in the ALU datapath. It accepts an opcode and a 4-bit operand under a START/BUSY handshake and reads the current accumulator value. It computes the result, single-cycle for logic/add/sub and four-cycle shift-add for multiply. It then issues exactly one write strobe (S) with W_DATA, which the accumulator captures on the following edge.

## Interface
- No parameters; data width fixed at 4 bits.
- CLK  in  1  system clock, all state updates on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- START  in  1  request; sampled only on edges where BUSY=0.
- OP  in  3  opcode, latched with START.
- B  in  4  operand, latched with START.
- ACC_IN  in  4  current accumulator value (accumulator R_DATA).
- BUSY  out  1  operation in progress; START ignored while high.
- S  out  1  accumulator write strobe, one-cycle pulse per operation.
- W_DATA  out  4  result to accumulator W_DATA; valid while S=1.
- DONE  out  1  completion pulse, coincident with S.
- CARRY  out  1  status flag of last completed operation.

## Operation
- Opcodes:
  - 000 LOAD: W=B.
  - 001 ADD: W=A+B, CARRY=bit4.
  - 010 SUB: W=A-B mod 16, CARRY=1 iff A<B.
  - 011 AND.
  - 100 OR.
  - 101 XOR.
  - 110 MUL: W=(A*B)[3:0], CARRY=1 iff A*B>15.
  - 111 NOT: W=~A.
- Logic ops, LOAD and NOT clear CARRY.
- A is ACC_IN as sampled in the first CALC cycle, not at the START edge. A back-to-back operation therefore sees the value just written.
- States:
  - IDLE: BUSY=0. START=1 latches OP and B, then goes to CALC.
  - CALC: non-MUL computes the result in one cycle, then goes to WRITE. MUL runs a 4-cycle shift-add: cycle i (i=0..3) adds A<<i to an 8-bit product if B[i]=1, using a 2-bit counter. After i=3 it goes to WRITE.
  - WRITE: S=1, DONE=1, W_DATA=result, CARRY updated. Goes to IDLE.
- S, DONE, W_DATA, BUSY and CARRY are registered outputs.
- W_DATA holds its last value after S falls.
- Reset values: state IDLE, BUSY=0, S=0, DONE=0, W_DATA=0000, CARRY=0.
- RST asserted mid-operation aborts immediately. No S pulse is issued for the aborted operation, and all outputs go to reset values.
- START held high continuously starts a new operation each time IDLE is reached.
- OP/B changes while BUSY=1 have no effect.

## Timing
- Edge k samples START=1 with BUSY=0.
- Non-MUL operations:
  - BUSY=1 from edge k+1.
  - S=DONE=1 from edge k+2 for exactly one cycle.
  - The accumulator captures at edge k+3.
  - BUSY=0 from edge k+3.
  - The next START can be sampled at k+3; its A (sampled k+4) equals the new accumulator value.
- MUL operations:
  - CALC occupies edges k+1..k+4.
  - S=DONE=1 from edge k+5.
  - BUSY=0 from edge k+6.
- S never asserts for two consecutive cycles.
- Exactly one S per accepted START.

## Structure
- Package acc_seq_pkg holds:
  - opcode constants (OP_LOAD..OP_NOT);
  - state encoding (ST_IDLE, ST_CALC, ST_WRITE);
  - DATA_W=4.
- Sub-module alu4_comb is purely combinational. Inputs are op, a, b; outputs are a 4-bit result and a carry, for all non-MUL opcodes.
- The MUL shift-add loop and the FSM stay in acc_sequencer.

## Test plan
- Reset, then ACC_IN=0101, START with OP=001 (ADD), B=0011 → S pulse at k+2 with W_DATA=1000, CARRY=0. BUSY low at k+3.
- ACC_IN=1100, SUB, B=1101 → W_DATA=1111, CARRY=1. Then ADD 1111+0001 → W_DATA=0000, CARRY=1.
- ACC_IN=0110, MUL, B=0011 → S at k+5, W_DATA=0010, CARRY=1 (18). Then 0011*0101 → W_DATA=1111, CARRY=0.
- Back-to-back with the accumulator model in the loop:
  - LOAD 0010, then START at k+3 with ADD 0001 → second result 0011. This proves A is sampled after the write.
  - Pulses of START while BUSY=1 are ignored: exactly one S per accepted START.
- RST asserted during the second MUL CALC cycle → outputs zero immediately. No S pulse occurs, and the next operation after release completes normally.
- Sweep all 8 opcodes × all 256 (A,B) pairs against a reference model. Check W_DATA, CARRY, and the latency (2 or 5 edges).
